dig_scan_ctrl: RTL and testbench

Parametrised, bus-mapped multiplexed seven-segment display controller. Sits behind the bus bridge as the display peripheral. It holds a 32-bit hex data register, a control register and a decimal-point mask. It time-multiplexes up to eight digits with per-digit decimal points, leading-zero suppression and per-digit blinking. The `sel` and `seg` outputs are aligned to the same clock edge.

---
 rtl/dig_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dig_scan_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dig_scan_ctrl.sv
// Bus-mapped multiplexed seven-segment display controller.
// Holds DATA/CTRL/DP registers and scans up to eight active-low digits with LZS and blink.
module dig_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int SCAN_CYC  = 200000,
    parameter int BLINK_CYC = 25000000
) (
    input  logic              clk,
    input  logic              s1,
    input  logic [31:0]       addr_to_dig,
    input  logic [31:0]       data_from_bridge2,
    input  logic              we_to_dig,
    input  logic [3:0]        be_to_dig,
    output logic [31:0]       rdata_from_dig,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        seg
);

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_CYC);
    localparam int BLINK_W = $clog2(BLINK_CYC);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYC - 1);
    localparam logic [SCAN_W-1:0]  SCAN_ONE   = SCAN_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_DP   = 2'd2;

    logic [31:0]        data_q, data_d;
    logic               en_q, en_d;
    logic               lzs_q, lzs_d;
    logic               blink_q, blink_d;
    logic [7:0]         bmask_q, bmask_d;
    logic [7:0]         dp_q, dp_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [DIGITS-1:0]  sel_q, sel_d;
    logic [7:0]         seg_q, seg_d;

    logic [1:0] reg_sel;
    logic       unused_addr;

    assign reg_sel     = addr_to_dig[3:2];
    assign unused_addr = ^{addr_to_dig[31:4], addr_to_dig[1:0]};

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Byte-enabled register writes; address slot 3 swallows writes.
    always_comb begin
        data_d  = data_q;
        en_d    = en_q;
        lzs_d   = lzs_q;
        blink_d = blink_q;
        bmask_d = bmask_q;
        dp_d    = dp_q;
        if (we_to_dig) begin
            case (reg_sel)
                REG_DATA: begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_to_dig[b]) data_d[8*b +: 8] = data_from_bridge2[8*b +: 8];
                    end
                end
                REG_CTRL: begin
                    if (be_to_dig[0]) {blink_d, lzs_d, en_d} = data_from_bridge2[2:0];
                    if (be_to_dig[1]) bmask_d = data_from_bridge2[15:8];
                end
                REG_DP: begin
                    if (be_to_dig[0]) dp_d = data_from_bridge2[7:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (reg_sel)
            REG_DATA: rdata_from_dig = data_q;
            REG_CTRL: rdata_from_dig = {16'h0, bmask_q, 5'h0, blink_q, lzs_q, en_q};
            REG_DP:   rdata_from_dig = {24'h0, dp_q};
            default:  rdata_from_dig = 32'h0;
        endcase
    end

    // Prescaler and digit index only run while enabled; the blink timer is free-running.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        if (!en_q) begin
            scan_cnt_d = '0;
            idx_d      = '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_ONE;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_ONE;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    logic [2:0] idx_ext;
    logic [3:0] nibble;
    logic [7:0] tail_zero;
    logic       zero_run;
    logic       lz_blank;
    logic       blink_blank;

    assign idx_ext = 3'(idx_q);
    assign nibble  = data_q[{idx_ext, 2'b00} +: 4];

    // tail_zero[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        tail_zero = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (data_q[4*i +: 4] == 4'h0);
            tail_zero[i] = zero_run;
        end
    end

    assign lz_blank    = lzs_q && (idx_ext != 3'd0) && tail_zero[idx_ext];
    assign blink_blank = blink_q && phase_q && bmask_q[idx_ext];

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            sel_d[i] = ~(en_q && (idx_ext == 3'(i)));
        end
        if (!en_q || blink_blank) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = {~dp_q[idx_ext], lz_blank ? 7'h7F : hex_glyph(nibble)};
        end
    end

    always_ff @(posedge clk or negedge s1) begin
        if (!s1) begin
            data_q      <= '0;
            en_q        <= 1'b0;
            lzs_q       <= 1'b0;
            blink_q     <= 1'b0;
            bmask_q     <= '0;
            dp_q        <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            sel_q       <= '1;
            seg_q       <= 8'hFF;
        end else begin
            data_q      <= data_d;
            en_q        <= en_d;
            lzs_q       <= lzs_d;
            blink_q     <= blink_d;
            bmask_q     <= bmask_d;
            dp_q        <= dp_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_dig_scan_ctrl.sv
// Self-checking bench for dig_scan_ctrl: an 8-digit and a 4-digit instance on a shared bus.
module tb_dig_scan_ctrl;

    logic        clk = 1'b0;
    logic        s1 = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        we8 = 1'b0;
    logic        we4 = 1'b0;
    logic [31:0] rdata8, rdata4;
    logic [7:0]  sel8, seg8, seg4;
    logic [3:0]  sel4;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Edges seen since reset released; the blink phase is derived from this.
    always @(posedge clk or negedge s1) begin
        if (!s1) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    dig_scan_ctrl #(.DIGITS(8), .SCAN_CYC(4), .BLINK_CYC(16)) u_dut8 (
        .clk(clk), .s1(s1), .addr_to_dig(addr), .data_from_bridge2(wdata),
        .we_to_dig(we8), .be_to_dig(be), .rdata_from_dig(rdata8), .sel(sel8), .seg(seg8)
    );

    dig_scan_ctrl #(.DIGITS(4), .SCAN_CYC(4), .BLINK_CYC(16)) u_dut4 (
        .clk(clk), .s1(s1), .addr_to_dig(addr), .data_from_bridge2(wdata),
        .we_to_dig(we4), .be_to_dig(be), .rdata_from_dig(rdata4), .sel(sel4), .seg(seg4)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
            4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
            4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
            4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic logic [31:0] exp8(input logic [31:0] data, input int d);
        logic [7:0] s;
        s = ~(8'h01 << d);
        return {16'h0, s, 1'b1, glyph(data[4*d +: 4])};
    endfunction

    function automatic logic [31:0] exp4(input logic [31:0] data, input int d);
        logic [3:0] s;
        s = ~(4'h1 << d);
        return {20'h0, s, 1'b1, glyph(data[4*d +: 4])};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input bit to4);
        @(negedge clk);
        addr = a; wdata = d; be = b;
        if (to4) we4 = 1'b1;
        else     we8 = 1'b1;
        @(posedge clk);
        #1;
        we8 = 1'b0; we4 = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input bit from4, output logic [31:0] v);
        @(negedge clk);
        addr = a;
        #1;
        v = from4 ? rdata4 : rdata8;
    endtask

    task automatic test_reset;
        logic [31:0] got, exp;
        s1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_FFFF);
        exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_out8: got %h exp %h", got, exp); end
        exp_q.push_back(32'h0000_0FFF);
        exp = exp_q.pop_front(); got = {20'h0, sel4, seg4}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_out4: got %h exp %h", got, exp); end
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back(32'h0);
            rd(32'(r * 4), 1'b0, got);
            exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_rd%0d: got %h exp %h", r, got, exp); end
        end
        @(negedge clk);
        s1 = 1'b1;
    endtask

    task automatic test_scan;
        logic [31:0] got, exp;
        wr(32'h0, 32'h89AB_CDEF, 4'hF, 1'b0);
        exp_q.push_back(32'h0000_FFFF);
        exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL scan_disabled: got %h exp %h", got, exp); end
        wr(32'h4, 32'h1, 4'hF, 1'b0);
        for (int c = 0; c < 40; c++) exp_q.push_back(exp8(32'h89AB_CDEF, (c / 4) % 8));
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL scan c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic test_write_on_tick;
        logic [31:0] got, exp;
        wr(32'h0, 32'h89AB_CDEF, 4'hF, 1'b0);
        wr(32'h4, 32'h1, 4'hF, 1'b0);
        for (int c = 0; c < 3; c++) exp_q.push_back(exp8(32'h89AB_CDEF, 0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL tick_pre c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h0, 32'h0123_4567, 4'hF, 1'b0);
        exp_q.push_back(exp8(32'h89AB_CDEF, 0));
        for (int c = 0; c < 8; c++) exp_q.push_back(exp8(32'h0123_4567, 1 + c / 4));
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL tick_post c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic test_byte_en;
        logic [31:0] got, exp;
        logic [31:0] ta [7];
        logic [31:0] td [7];
        logic [3:0]  tb [7];
        logic [31:0] te [7];
        wr(32'h0, 32'h0, 4'hF, 1'b0);
        ta = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h8, 32'hC};
        td = '{32'h1234_5678, 32'h1, 32'hFFFF_FFFF, 32'h0000_FF07, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tb = '{4'b0010, 4'hF, 4'h0, 4'b0010, 4'hF, 4'hF, 4'hF};
        te = '{32'h0000_5600, 32'h1, 32'h1, 32'h0000_FF01, 32'h0000_FF07, 32'h0000_00FF, 32'h0};
        for (int i = 0; i < 7; i++) begin
            wr(ta[i], td[i], tb[i], 1'b0);
            exp_q.push_back(te[i]);
            rd(ta[i], 1'b0, got);
            exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL byte_en%0d: got %h exp %h", i, got, exp); end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b0);
        wr(32'h8, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic test_lzs;
        logic [31:0] got, exp;
        logic [7:0]  s [8];
        logic [7:0]  sl;
        wr(32'h0, 32'h0000_0405, 4'hF, 1'b0);
        wr(32'h4, 32'h3, 4'hF, 1'b0);
        s = '{8'h92, 8'hC0, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int c = 0; c < 32; c++) begin
            sl = ~(8'h01 << (c / 4));
            exp_q.push_back({16'h0, sl, s[c / 4]});
        end
        for (int c = 0; c < 32; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL lzs c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b0);
        wr(32'h0, 32'h0, 4'hF, 1'b0);
        wr(32'h4, 32'h3, 4'hF, 1'b0);
        for (int c = 0; c < 16; c++) begin
            sl = ~(8'h01 << (c / 4));
            exp_q.push_back({16'h0, sl, (c < 4) ? 8'hC0 : 8'hFF});
        end
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL lzs_zero c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic test_dp_blink;
        logic [31:0] got, exp;
        logic [7:0]  s [8];
        logic [7:0]  sl;
        int base, d, ph;
        s = '{8'h92, 8'h40, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        wr(32'h8, 32'h2, 4'hF, 1'b0);
        wr(32'h0, 32'h0000_0405, 4'hF, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                wr(32'h4, 32'h0, 4'hF, 1'b0);
                // Re-enable half a frame later so digit 0 meets the other blink phase.
                while (((cyc + 1) % 32) != ((base + 16) % 32)) begin
                    @(posedge clk); #1;
                end
            end
            wr(32'h4, 32'h0000_0105, 4'hF, 1'b0);
            base = cyc;
            for (int c = 0; c < 32; c++) begin
                d  = c / 4;
                ph = ((base + c) / 16) % 2;
                sl = ~(8'h01 << d);
                exp_q.push_back({16'h0, sl, (d == 0 && ph == 1) ? 8'hFF : s[d]});
            end
            for (int c = 0; c < 32; c++) begin
                @(posedge clk); #1;
                exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
                if (got !== exp) begin n_fail++; $display("FAIL blink p%0d c%0d: got %h exp %h", pass, c, got, exp); end
            end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b0);
        wr(32'h8, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic test_disable_mid;
        logic [31:0] got, exp;
        wr(32'h0, 32'h89AB_CDEF, 4'hF, 1'b0);
        wr(32'h4, 32'h1, 4'hF, 1'b0);
        for (int c = 0; c < 13; c++) exp_q.push_back(exp8(32'h89AB_CDEF, c / 4));
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL dis_pre c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b0);
        exp_q.push_back(32'h0000_F7C6);
        for (int c = 0; c < 5; c++) exp_q.push_back(32'h0000_FFFF);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL dis_blank c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h4, 32'h1, 4'hF, 1'b0);
        for (int c = 0; c < 8; c++) exp_q.push_back(exp8(32'h89AB_CDEF, c / 4));
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL dis_reen c%0d: got %h exp %h", c, got, exp); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] got, exp;
        wr(32'h8, 32'hFF, 4'hF, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        s1 = 1'b0;
        #1;
        exp_q.push_back(32'h0000_FFFF);
        exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL rstmid_out: got %h exp %h", got, exp); end
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(32'h0);
            rd(32'(r * 4), 1'b0, got);
            exp = exp_q.pop_front(); n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL rstmid_rd%0d: got %h exp %h", r, got, exp); end
        end
        @(negedge clk);
        s1 = 1'b1;
        for (int c = 0; c < 4; c++) exp_q.push_back(32'h0000_FFFF);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {16'h0, sel8, seg8}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL rstmid_post c%0d: got %h exp %h", c, got, exp); end
        end
    endtask

    task automatic test_digits4;
        logic [31:0] got, exp;
        logic [3:0]  sl;
        wr(32'h0, 32'hABCD_1234, 4'hF, 1'b1);
        exp_q.push_back(32'hABCD_1234);
        rd(32'h0, 1'b1, got);
        exp = exp_q.pop_front(); n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL d4_rd: got %h exp %h", got, exp); end
        wr(32'h4, 32'h1, 4'hF, 1'b1);
        for (int c = 0; c < 20; c++) exp_q.push_back(exp4(32'hABCD_1234, (c / 4) % 4));
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {20'h0, sel4, seg4}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL d4_scan c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b1);
        wr(32'h0, 32'hFFFF_0000, 4'hF, 1'b1);
        wr(32'h4, 32'h3, 4'hF, 1'b1);
        for (int c = 0; c < 16; c++) begin
            sl = ~(4'h1 << (c / 4));
            exp_q.push_back({20'h0, sl, (c < 4) ? 8'hC0 : 8'hFF});
        end
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front(); got = {20'h0, sel4, seg4}; n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL d4_lzs c%0d: got %h exp %h", c, got, exp); end
        end
        wr(32'h4, 32'h0, 4'hF, 1'b1);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write_on_tick();
        test_byte_en();
        test_lzs();
        test_dp_blink();
        test_disable_mid();
        test_reset_mid();
        test_digits4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
